line_rotator: RTL and testbench
===============================

// Module: line_rotator
// PURPOSE
// - Downstream consumer of the cut interpolator's cut_position: applies the cut to the video stream.
// - Buffers one active line of 4:2:2 CrYCbY samples in a ping-pong RAM.
// - Replays the previous line rotated: samples [cut..LINE_SAMPLES-1], then [0..cut-1].
// - Sits between the active-video extractor and the re-inserter in the line-rotation scrambler path.
// PARAMETERS
// - LINE_SAMPLES  1440  8-bit samples per active line (720 px x 2)
// - ADDR_W        11    line buffer address width
// - CUT_W         11    cut_position width
// PORTS
// - clk            in   1       system clock; all logic on rising edge
// - reset          in   1       synchronous, active-high
// - enable         in   1       1 = rotate; 0 = pass through with the same one-line delay (cut forced to 0)
// - in_sample      in   8       input sample
// - in_valid       in   1       in_sample is valid this cycle
// - in_line_start  in   1       first sample of an active line; honoured only with in_valid
// - cut_position   in   CUT_W   rotation point; sampled on in_valid & in_line_start
// - out_sample     out  8       rotated output sample
// - out_valid      out  1       out_sample is valid
// - out_line_start out  1       first sample of a rotated line
// BEHAVIOUR
// - Reset: out_sample=0, out_valid=0, out_line_start=0; write/read counters=0; both bank-valid flags=0;
//   write bank=0. RAM contents are not cleared.
// - Write side: each in_valid writes in_sample to wr_bank[wr_cnt], then wr_cnt++.
//   Samples with wr_cnt>=LINE_SAMPLES are dropped and wr_cnt saturates.
// - Line boundary (in_valid & in_line_start):
//   - the current write bank becomes the read bank;
//   - its valid flag = (wr_cnt==LINE_SAMPLES);
//   - the new write bank starts at address 0 with this sample;
//   - rd_cnt=0; rd_ptr=latched cut of the line just closed.
// - Cut latch at line start: cut_l = enable ? {cut_position[CUT_W-1:2],2'b00} : 0.
//   cut_position>=LINE_SAMPLES gives cut_l=0, so CrYCbY groups are never split.
// - Read side is paced by the write side. Each in_valid cycle with read bank valid and rd_cnt<LINE_SAMPLES:
//   - reads RAM[rd_ptr];
//   - rd_ptr = (rd_ptr==LINE_SAMPLES-1) ? 0 : rd_ptr+1 (no divider or modulo);
//   - rd_cnt++.
// - Latency: out_valid asserts exactly 2 cycles after the triggering in_valid
//   (1 cycle sync RAM read, 1 cycle output register). Output line N+1 carries input line N.
// - out_line_start = 1 with the first sample (rd_cnt==0) of each replayed line, 0 otherwise.
// - In idle cycles (no read) out_valid=0 and out_sample holds its last value.
// - First line after reset: no read bank valid, so out_valid stays 0 for the whole line.
// - Short line (in_line_start before LINE_SAMPLES writes): bank marked invalid; its readout emits no
//   out_valid. Reads of the previous bank still pending are abandoned at the boundary.
// - Long line: extra inputs produce no writes and no reads (rd_cnt saturates).
// - in_line_start without in_valid: ignored.
// - Reset mid-line: outputs are 0 on the next cycle; resumes as after power-on reset.
// STRUCTURE
// - Shared header line_rotation_defs.vh: LINE_SAMPLES, SAMPLES_PER_GROUP=4, CUT_W, ADDR_W.
//   The cut interpolator uses the same header.
// - Sub-module line_buffer_ram: simple dual-port RAM, 2*LINE_SAMPLES x 8, 1-cycle registered read;
//   address = {bank, addr}.
// - Top level: write counter, bank/valid flags, cut latch, read pointer, output register.
// TESTING
// 1. Reset; 3 full lines, sample i of line k = (i+k)&8'hFF, cut=16 each line
//    -> line 2 out[0]=in1[16], out[1423]=in1[1439], out[1424]=in1[0]; no output during line 0.
// 2. cut=1416 (raw 255 after interpolation)
//    -> out[0]=in[1416], out[23]=in[1439], out[24]=in[0]; 1440 out_valid pulses.
// 3. cut=11'd1027
//    -> behaves as 1024.
// 4. cut=11'd1440 or enable=0
//    -> out[j]=in[j] one line later.
// 5. One line of 1000 samples between full lines
//    -> its replay slot has zero out_valid; the following full line rotates correctly.
// 6. in_valid toggling 1,0,1,0
//    -> out_valid shows the same pattern delayed exactly 2 cycles; out_line_start on first valid only.
// 7. reset asserted at sample 700 of a line
//    -> out_valid=0 next cycle; no output for the first full line after reset.

Source files
------------

// File: rtl/line_rotator_pkg.sv
// Shared constants and helpers for the line-rotation scrambler datapath.
// The cut interpolator and the line rotator both import this package.
package line_rotator_pkg;

    localparam int LINE_SAMPLES      = 1440;
    localparam int SAMPLES_PER_GROUP = 4;
    localparam int ADDR_W            = 11;
    localparam int CUT_W             = 11;
    localparam int DATA_W            = 8;

    // Each bank gets a power-of-two half of the RAM so the address is just {bank, addr}.
    localparam int RAM_DEPTH = 2 ** (ADDR_W + 1);

    localparam logic [ADDR_W-1:0] LINE_LEN  = ADDR_W'(LINE_SAMPLES);
    localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(LINE_SAMPLES - 1);
    localparam logic [CUT_W-1:0]  CUT_LIMIT = CUT_W'(LINE_SAMPLES);
    localparam logic [CUT_W-1:0]  CUT_MASK  = ~CUT_W'(SAMPLES_PER_GROUP - 1);

    // Snap the cut to a CrYCbY group boundary; out-of-range cuts or a disabled rotator mean no rotation.
    function automatic logic [CUT_W-1:0] latchCut(input logic [CUT_W-1:0] cut, input logic en);
        if (!en || (cut >= CUT_LIMIT)) begin
            return '0;
        end
        return cut & CUT_MASK;
    endfunction

endpackage

// File: rtl/line_rotator_ram.sv
// Simple dual-port line buffer with one registered read port.
// Holds two line banks, addressed as {bank, sample index}.
module line_rotator_ram
    import line_rotator_pkg::*;
(
    input  logic              clk,
    input  logic              i_wrEn,
    input  logic [ADDR_W:0]   i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic              i_rdEn,
    input  logic [ADDR_W:0]   i_rdAddr,
    output logic [DATA_W-1:0] o_rdData
);

    logic [DATA_W-1:0] r_mem [0:RAM_DEPTH-1];
    logic [DATA_W-1:0] r_rdData;

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
        if (i_rdEn) begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/line_rotator.sv
// Buffers one active line in a ping-pong RAM and replays it on the next line,
// starting at the latched cut and wrapping around to sample 0.
module line_rotator
    import line_rotator_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] in_sample,
    input  logic              in_valid,
    input  logic              in_line_start,
    input  logic [CUT_W-1:0]  cut_position,
    output logic [DATA_W-1:0] out_sample,
    output logic              out_valid,
    output logic              out_line_start
);

    logic              r_wrBank;
    logic [ADDR_W-1:0] r_wrCnt;
    logic [1:0]        r_bankValid;
    logic              r_rdBank;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W-1:0] r_rdCnt;
    logic [CUT_W-1:0]  r_cutL;
    logic              r_rdValid1;
    logic              r_rdStart1;
    logic [DATA_W-1:0] r_outSample;
    logic              r_outValid;
    logic              r_outLineStart;

    logic              w_lineStart;
    logic              w_wrEn;
    logic              w_wrBank;
    logic [ADDR_W-1:0] w_wrAddr;
    logic              w_rdBank;
    logic              w_rdBankValid;
    logic [ADDR_W-1:0] w_rdPtr;
    logic [ADDR_W-1:0] w_rdCnt;
    logic [ADDR_W-1:0] w_rdPtrNext;
    logic              w_rdEn;
    logic [DATA_W-1:0] w_ramData;

    // On a line boundary the read side already works on the bank being closed this cycle.
    assign w_lineStart   = in_valid & in_line_start;
    assign w_wrBank      = w_lineStart ? ~r_wrBank : r_wrBank;
    assign w_wrAddr      = w_lineStart ? '0 : r_wrCnt;
    assign w_wrEn        = in_valid & (w_lineStart | (r_wrCnt < LINE_LEN));
    assign w_rdBank      = w_lineStart ? r_wrBank : r_rdBank;
    assign w_rdBankValid = w_lineStart ? (r_wrCnt == LINE_LEN) : r_bankValid[r_rdBank];
    assign w_rdPtr       = w_lineStart ? ADDR_W'(r_cutL) : r_rdPtr;
    assign w_rdCnt       = w_lineStart ? '0 : r_rdCnt;
    assign w_rdEn        = in_valid & w_rdBankValid & (w_rdCnt < LINE_LEN);
    assign w_rdPtrNext   = (w_rdPtr == LINE_LAST) ? '0 : w_rdPtr + ADDR_W'(1);

    line_rotator_ram u_ram (
        .clk      (clk),
        .i_wrEn   (w_wrEn),
        .i_wrAddr ({w_wrBank, w_wrAddr}),
        .i_wrData (in_sample),
        .i_rdEn   (w_rdEn),
        .i_rdAddr ({w_rdBank, w_rdPtr}),
        .o_rdData (w_ramData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrBank    <= 1'b0;
            r_wrCnt     <= '0;
            r_bankValid <= 2'b00;
            r_rdBank    <= 1'b0;
            r_rdPtr     <= '0;
            r_rdCnt     <= '0;
            r_cutL      <= '0;
        end else begin
            if (w_lineStart) begin
                r_wrBank                <= ~r_wrBank;
                r_wrCnt                 <= ADDR_W'(1);
                r_bankValid[r_wrBank]   <= (r_wrCnt == LINE_LEN);
                r_bankValid[~r_wrBank]  <= 1'b0;
                r_rdBank                <= r_wrBank;
                r_cutL                  <= latchCut(cut_position, enable);
            end else if (in_valid && (r_wrCnt < LINE_LEN)) begin
                r_wrCnt <= r_wrCnt + ADDR_W'(1);
            end
            if (w_lineStart || w_rdEn) begin
                r_rdPtr <= w_rdEn ? w_rdPtrNext : w_rdPtr;
                r_rdCnt <= w_rdEn ? (w_rdCnt + ADDR_W'(1)) : w_rdCnt;
            end
        end
    end

    // Stage 1 tracks the RAM read in flight; stage 2 is the output register that holds when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdValid1     <= 1'b0;
            r_rdStart1     <= 1'b0;
            r_outSample    <= '0;
            r_outValid     <= 1'b0;
            r_outLineStart <= 1'b0;
        end else begin
            r_rdValid1     <= w_rdEn;
            r_rdStart1     <= w_rdEn & (w_rdCnt == '0);
            r_outValid     <= r_rdValid1;
            r_outLineStart <= r_rdStart1;
            if (r_rdValid1) begin
                r_outSample <= w_ramData;
            end
        end
    end

    assign out_sample     = r_outSample;
    assign out_valid      = r_outValid;
    assign out_line_start = r_outLineStart;

endmodule

// File: tb/tb_line_rotator.sv
// Randomised and directed bench for line_rotator, checked every cycle against a
// line-level reference model plus hand-computed replay values.
module tb_line_rotator;

    localparam int LS     = 1440;
    localparam int MAXCYC = 80000;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  in_sample;
    logic        in_valid;
    logic        in_line_start;
    logic [10:0] cut_position;
    logic [7:0]  out_sample;
    logic        out_valid;
    logic        out_line_start;

    always #5 clk = ~clk;

    line_rotator dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .in_sample      (in_sample),
        .in_valid       (in_valid),
        .in_line_start  (in_line_start),
        .cut_position   (cut_position),
        .out_sample     (out_sample),
        .out_valid      (out_valid),
        .out_line_start (out_line_start)
    );

    int nVectors     = 0;
    int nMiscompares = 0;

    int   cyc       = 0;
    bit   seenReset = 1'b0;
    bit   expR  [MAXCYC];
    bit   expV  [MAXCYC];
    bit   expSt [MAXCYC];
    logic [7:0] expS [MAXCYC];

    logic [7:0] curLine  [LS];
    logic [7:0] prevLine [LS];
    int   curCnt    = 0;
    int   curCut    = 0;
    int   prevCut   = 0;
    int   rdJ       = LS;
    bit   prevValid = 1'b0;

    logic [7:0] lastS = 8'h00;
    int   cap [LS];
    int   capIdx   = 0;
    int   pulseCnt = 0;

    function automatic int effCut(input int raw, input bit en);
        if (!en || raw >= LS) return 0;
        return raw - (raw % 4);
    endfunction

    // Reference model: whole-line arrays; the replay of the previous line is (cut + j) mod LS.
    always @(posedge clk) begin
        int nx;
        nx = cyc + 1;
        if (reset) begin
            seenReset = 1'b1;
            curCnt    = 0;
            curCut    = 0;
            prevValid = 1'b0;
            rdJ       = LS;
            if (nx < MAXCYC) begin
                expR[cyc]  = 1'b1;
                expV[cyc]  = 1'b0;
                expSt[cyc] = 1'b0;
                expV[nx]   = 1'b0;
            end
        end else if (in_valid) begin
            if (in_line_start) begin
                prevLine   = curLine;
                prevValid  = (curCnt == LS);
                prevCut    = curCut;
                curCut     = effCut(int'(cut_position), enable);
                rdJ        = 0;
                curLine[0] = in_sample;
                curCnt     = 1;
            end else if (curCnt < LS) begin
                curLine[curCnt] = in_sample;
                curCnt++;
            end
            if (prevValid && rdJ < LS && nx < MAXCYC) begin
                expV[nx]  = 1'b1;
                expS[nx]  = prevLine[(prevCut + rdJ) % LS];
                expSt[nx] = (rdJ == 0);
                rdJ++;
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        int m;
        if (seenReset) begin
            m = cyc - 1;
            if (m < MAXCYC) begin
                if (expR[m]) lastS = 8'h00;
                else if (expV[m]) lastS = expS[m];
                nVectors++;
                if (out_valid !== expV[m] || out_line_start !== expSt[m] || out_sample !== lastS) begin
                    nMiscompares++;
                    $display("[TB] FAIL cycle %0d: got valid=%b start=%b sample=%h, expected valid=%b start=%b sample=%h",
                             m, out_valid, out_line_start, out_sample, expV[m], expSt[m], lastS);
                end
            end
            if (out_valid === 1'b1) begin
                pulseCnt++;
                if (out_line_start === 1'b1) capIdx = 0;
                if (capIdx < LS) cap[capIdx] = int'(out_sample);
                capIdx++;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nVectors++;
        if (actual != expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid      = 1'b0;
            in_line_start = 1'($urandom_range(0, 1));
            in_sample     = 8'($urandom);
            cut_position  = 11'($urandom);
        end
    endtask

    // mode 0: back-to-back samples, 1: alternate valid/idle, 2: random gaps. k < 0 gives random data.
    task automatic applyStimulus(input int len, input int cutVal, input bit en, input int k,
                                 input int mode, input int tail);
        enable = en;
        for (int i = 0; i < len; i++) begin
            if (i > 0 && (mode == 1 || (mode == 2 && $urandom_range(0, 4) == 0))) idle(1);
            @(negedge clk);
            in_valid      = 1'b1;
            in_line_start = (i == 0);
            in_sample     = (k >= 0) ? 8'((i + k) & 255) : 8'($urandom);
            cut_position  = (i == 0) ? 11'(cutVal) : 11'($urandom);
        end
        idle(tail);
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset         = 1'b1;
        in_valid      = 1'b1;
        in_line_start = 1'b0;
        in_sample     = 8'hAA;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        checkOutput("reset_mid_valid", int'(out_valid), 0);
        checkOutput("reset_mid_sample", int'(out_sample), 0);
    endtask

    initial begin
        reset         = 1'b1;
        enable        = 1'b1;
        in_valid      = 1'b0;
        in_line_start = 1'b0;
        in_sample     = 8'h00;
        cut_position  = 11'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_sample", int'(out_sample), 0);
        reset = 1'b0;

        pulseCnt = 0;
        applyStimulus(LS, 16, 1'b1, 0, 0, 3);
        checkOutput("line0_no_output", pulseCnt, 0);
        applyStimulus(LS, 16, 1'b1, 1, 0, 3);
        pulseCnt = 0;
        applyStimulus(LS, 16, 1'b1, 2, 0, 3);
        checkOutput("cut16_out0", cap[0], 17);
        checkOutput("cut16_out1423", cap[1423], 160);
        checkOutput("cut16_out1424", cap[1424], 1);
        checkOutput("cut16_pulses", pulseCnt, LS);

        applyStimulus(LS, 1416, 1'b1, 3, 0, 3);
        pulseCnt = 0;
        applyStimulus(LS, 1027, 1'b1, 4, 0, 3);
        checkOutput("cut1416_out0", cap[0], 139);
        checkOutput("cut1416_out23", cap[23], 162);
        checkOutput("cut1416_out24", cap[24], 3);
        checkOutput("cut1416_pulses", pulseCnt, LS);

        applyStimulus(LS, 1440, 1'b1, 5, 0, 3);
        checkOutput("cut1027_out0", cap[0], 4);
        checkOutput("cut1027_out415", cap[415], 163);
        checkOutput("cut1027_out416", cap[416], 4);

        applyStimulus(LS, 500, 1'b0, 6, 0, 3);
        checkOutput("cut1440_out0", cap[0], 5);
        checkOutput("cut1440_out100", cap[100], 105);

        applyStimulus(LS, 40, 1'b1, 7, 0, 3);
        checkOutput("disabled_out0", cap[0], 6);
        checkOutput("disabled_out300", cap[300], 50);

        pulseCnt = 0;
        applyStimulus(1000, 12, 1'b1, 8, 0, 3);
        checkOutput("abandoned_pulses", pulseCnt, 1000);
        checkOutput("abandoned_out0", cap[0], 47);
        pulseCnt = 0;
        applyStimulus(LS, 8, 1'b1, 9, 0, 3);
        checkOutput("short_line_pulses", pulseCnt, 0);
        pulseCnt = 0;
        applyStimulus(LS, 0, 1'b1, 10, 0, 3);
        checkOutput("after_short_pulses", pulseCnt, LS);
        checkOutput("after_short_out0", cap[0], 17);
        checkOutput("after_short_out1431", cap[1431], 168);
        checkOutput("after_short_out1432", cap[1432], 9);

        applyStimulus(LS, 4, 1'b1, 11, 1, 3);
        pulseCnt = 0;
        applyStimulus(LS, 0, 1'b1, 12, 1, 3);
        checkOutput("toggle_pulses", pulseCnt, LS);
        checkOutput("toggle_out0", cap[0], 15);

        for (int r = 0; r < 4; r++) begin
            applyStimulus($urandom_range(1436, 1444), $urandom_range(0, 2047),
                          1'($urandom_range(0, 3) != 0), -1, 2, 3);
        end

        applyStimulus(LS, 20, 1'b1, 0, 0, 0);
        applyStimulus(700, 0, 1'b1, 0, 0, 0);
        applyReset();
        idle(2);
        pulseCnt = 0;
        applyStimulus(LS, 0, 1'b1, 1, 0, 3);
        checkOutput("post_reset_pulses", pulseCnt, 0);
        pulseCnt = 0;
        applyStimulus(LS, 0, 1'b1, 2, 0, 3);
        checkOutput("post_reset_replay_pulses", pulseCnt, LS);
        checkOutput("post_reset_out0", cap[0], 1);
        checkOutput("post_reset_out1439", cap[1439], 160);

        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
